lfsr_rng_stream: RTL



---
 rtl/rng_pkg.sv | 22 ++
 rtl/lfsr_rng_stream_step.sv | 24 ++
 rtl/lfsr_rng_stream.sv | 104 ++++++++++
 3 files changed

// File: rtl/rng_pkg.sv
// Shared definitions for the LFSR random stream.
// Holds the default feedback masks per common width and the 32-bit word type.
package rng_pkg;

  typedef logic [31:0] rng_word_t;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam rng_word_t   TAPS_32 = 32'h80000057;

  // Default feedback mask for a width; unknown widths fall back to the MSB-only
  // mask, which keeps bit WIDTH-1 set but is not maximal length.
  function automatic logic [63:0] default_taps(input int w);
    case (w)
      8:       default_taps = 64'(TAPS_8);
      16:      default_taps = 64'(TAPS_16);
      32:      default_taps = 64'(TAPS_32);
      default: default_taps = 64'd1 << (w - 1);
    endcase
  endfunction

endpackage

// File: rtl/lfsr_rng_stream_step.sv
// lfsr_step_comb: purely combinational multi-step Fibonacci LFSR advance.
// Ports:
//   s     in   WIDTH  current state
//   next  out  WIDTH  state after STEPS single shifts
// One shift is {s[WIDTH-2:0], ^(s & TAPS)}; the loop unrolls STEPS of them.
module lfsr_step_comb
  import rng_pkg::*;
#(
  parameter int              WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter int              STEPS = 1
) (
  input  logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] next
);

  always_comb begin
    next = s;
    for (int i = 0; i < STEPS; i++) begin
      next = {next[WIDTH-2:0], ^(next & TAPS)};
    end
  end

endmodule

// File: rtl/lfsr_rng_stream.sv
// lfsr_rng_stream: Fibonacci-LFSR pseudo-random source with a valid/ready stream.
// Ports:
//   clk         in   1      clock
//   rstn        in   1      synchronous reset, active low
//   en          in   1      permit generation of new words
//   seed_valid  in   1      load seed this cycle (always accepted)
//   seed        in   WIDTH  new seed, stored with LSB forced to 1
//   out_valid   out  1      out_data holds an unconsumed word
//   out_ready   in   1      consumer accepts out_data when out_valid
//   out_data    out  WIDTH  random word
//   lockup      out  1      one-cycle pulse when an all-zero state is reloaded
//   word_cnt    out  CNT_W  words produced since reset/reseed, wraps
module lfsr_rng_stream
  import rng_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(default_taps(WIDTH)),
  parameter int               STEPS        = 1,
  parameter rng_word_t        DEFAULT_SEED = 32'h1,
  parameter int               CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             lockup,
  output logic [CNT_W-1:0] word_cnt
);

  // LSB forced high so the reload value can never itself be the lock-up state.
  localparam logic [WIDTH-1:0] RELOAD = WIDTH'(DEFAULT_SEED) | WIDTH'(1);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             lockup_q, lockup_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] next_state;
  logic             advance;

  lfsr_step_comb #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEPS (STEPS)
  ) u_step (
    .s    (state_q),
    .next (next_state)
  );

  assign advance = en && (!valid_q || out_ready);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    lockup_d = 1'b0;
    if (seed_valid) begin
      // Reseed wins over everything, including a handshake in the same cycle.
      state_d = {seed[WIDTH-1:1], 1'b1};
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (advance) begin
      if (state_q == '0) begin
        state_d  = RELOAD;
        lockup_d = 1'b1;
        valid_d  = 1'b0;
      end else begin
        state_d = next_state;
        data_d  = next_state;
        valid_d = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign lockup    = lockup_q;
  assign word_cnt  = cnt_q;

endmodule
